// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the bus-owner enum and a burst-length helper
// used by the CPU/DMA arbiter and its weighted round-robin scheduler.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  // Beats in a fixed-length burst; 0 marks an undefined-length INCR.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    case (hburst)
      HBURST_SINGLE: beats = 5'd1;
      HBURST_INCR:   beats = 5'd0;
      HBURST_WRAP4,
      HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,
      HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16,
      HBURST_INCR16: beats = 5'd16;
      default:       beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_wrr_sched.sv
// Weighted round-robin winner selection between CPU and DMA; the CPU may
// win CPU_WEIGHT consecutive contended tenures before DMA gets one.
module ahb_wrr_sched
  import ahb_pkg::*;
#(
  parameter int unsigned CPU_WEIGHT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boundary,
  input  logic       cpu_req,
  input  logic       dma_req,
  output owner_t     winner,
  output logic [3:0] cpu_cnt
);

  localparam logic [3:0] WEIGHT = 4'(CPU_WEIGHT);

  logic [3:0] cpu_cnt_r;
  logic [3:0] cpu_cnt_nxt_s;
  owner_t     winner_s;

  // Winner and next contention count for the current request pattern
  always_comb begin
    winner_s      = OWNER_CPU;
    cpu_cnt_nxt_s = cpu_cnt_r;
    if (cpu_req && dma_req) begin
      if (cpu_cnt_r < WEIGHT) begin
        winner_s      = OWNER_CPU;
        cpu_cnt_nxt_s = cpu_cnt_r + 4'd1;
      end else begin
        winner_s      = OWNER_DMA;
        cpu_cnt_nxt_s = 4'd0;
      end
    end else if (cpu_req) begin
      winner_s      = OWNER_CPU;
      cpu_cnt_nxt_s = cpu_cnt_r;
    end else if (dma_req) begin
      winner_s      = OWNER_DMA;
      cpu_cnt_nxt_s = 4'd0;
    end else begin
      winner_s      = OWNER_CPU;
      cpu_cnt_nxt_s = cpu_cnt_r;
    end
  end

  // Contention count only advances when an arbitration actually happens
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_cnt_r <= 4'd0;
    end else if (boundary) begin
      cpu_cnt_r <= cpu_cnt_nxt_s;
    end else begin
      cpu_cnt_r <= cpu_cnt_r;
    end
  end

  assign winner  = winner_s;
  assign cpu_cnt = cpu_cnt_r;

endmodule

// File: rtl/ahb_master_arbiter_mux.sv
// Two-master AHB-Lite arbiter and bus mux: tracks bursts/locks to find legal
// handover points, registers the grant and muxes address/data phases.
module ahb_master_arbiter_mux
  import ahb_pkg::*;
#(
  parameter int unsigned CPU_WEIGHT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        dma_req,
  input  logic [31:0] cpu_haddr,
  input  logic [31:0] dma_haddr,
  input  logic [1:0]  cpu_htrans,
  input  logic [1:0]  dma_htrans,
  input  logic        cpu_hwrite,
  input  logic        dma_hwrite,
  input  logic [2:0]  cpu_hsize,
  input  logic [2:0]  dma_hsize,
  input  logic [2:0]  cpu_hburst,
  input  logic [2:0]  dma_hburst,
  input  logic        cpu_hmastlock,
  input  logic        dma_hmastlock,
  input  logic [31:0] cpu_hwdata,
  input  logic [31:0] dma_hwdata,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  output logic        cpu_grant,
  output logic        dma_grant
);

  owner_t      addr_owner_r;
  owner_t      data_owner_r;
  owner_t      addr_owner_nxt_s;
  owner_t      winner_s;
  logic [4:0]  beats_left_r;
  logic [4:0]  beats_left_nxt_s;
  logic [4:0]  burst_len_s;
  logic        incr_active_r;
  logic        incr_active_nxt_s;
  logic        boundary_s;
  logic        cpu_grant_r;
  logic        dma_grant_r;
  logic [3:0]  cpu_cnt_s;

  // Address-phase mux: the non-owner's signals never reach the bus
  always_comb begin
    HADDR     = cpu_haddr;
    HTRANS    = cpu_htrans;
    HWRITE    = cpu_hwrite;
    HSIZE     = cpu_hsize;
    HBURST    = cpu_hburst;
    HMASTLOCK = cpu_hmastlock;
    if (addr_owner_r == OWNER_DMA) begin
      HADDR     = dma_haddr;
      HTRANS    = dma_htrans;
      HWRITE    = dma_hwrite;
      HSIZE     = dma_hsize;
      HBURST    = dma_hburst;
      HMASTLOCK = dma_hmastlock;
    end else begin
      HADDR     = cpu_haddr;
      HTRANS    = cpu_htrans;
      HWRITE    = cpu_hwrite;
      HSIZE     = cpu_hsize;
      HBURST    = cpu_hburst;
      HMASTLOCK = cpu_hmastlock;
    end
  end

  // Data-phase mux follows the owner of the previous accepted address phase
  always_comb begin
    HWDATA = cpu_hwdata;
    if (data_owner_r == OWNER_DMA) begin
      HWDATA = dma_hwdata;
    end else begin
      HWDATA = cpu_hwdata;
    end
  end

  // Legal handover point; an error response ends any tenure, even a locked one
  always_comb begin
    boundary_s = 1'b0;
    if (!HREADY) begin
      boundary_s = 1'b0;
    end else if (HRESP) begin
      boundary_s = 1'b1;
    end else if (!HMASTLOCK) begin
      case (HTRANS)
        HTRANS_IDLE:   boundary_s = 1'b1;
        HTRANS_NONSEQ: boundary_s = (HBURST == HBURST_SINGLE);
        HTRANS_SEQ:    boundary_s = !incr_active_r && (beats_left_r == 5'd1);
        HTRANS_BUSY:   boundary_s = 1'b0;
        default:       boundary_s = 1'b0;
      endcase
    end else begin
      boundary_s = 1'b0;
    end
  end

  // Next burst-tracking state for an accepted transfer
  always_comb begin
    beats_left_nxt_s  = beats_left_r;
    incr_active_nxt_s = incr_active_r;
    burst_len_s       = burst_beats(HBURST);
    if (HRESP) begin
      beats_left_nxt_s  = 5'd0;
      incr_active_nxt_s = 1'b0;
    end else begin
      case (HTRANS)
        HTRANS_NONSEQ: begin
          if (burst_len_s == 5'd0) begin
            incr_active_nxt_s = 1'b1;
          end else if (burst_len_s > 5'd1) begin
            beats_left_nxt_s = burst_len_s - 5'd1;
          end else begin
            beats_left_nxt_s = beats_left_r;
          end
        end
        HTRANS_SEQ: begin
          if (beats_left_r != 5'd0) begin
            beats_left_nxt_s = beats_left_r - 5'd1;
          end else begin
            beats_left_nxt_s = beats_left_r;
          end
        end
        HTRANS_IDLE: incr_active_nxt_s = 1'b0;
        HTRANS_BUSY: incr_active_nxt_s = incr_active_r;
        default:     incr_active_nxt_s = incr_active_r;
      endcase
    end
  end

  ahb_wrr_sched #(
    .CPU_WEIGHT (CPU_WEIGHT)
  ) u_sched (
    .clk      (clk),
    .reset    (reset),
    .boundary (boundary_s),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .winner   (winner_s),
    .cpu_cnt  (cpu_cnt_s)
  );

  // Owner to load on this edge
  always_comb begin
    addr_owner_nxt_s = addr_owner_r;
    if (boundary_s) begin
      addr_owner_nxt_s = winner_s;
    end else begin
      addr_owner_nxt_s = addr_owner_r;
    end
  end

  // Ownership, grants and burst state all freeze while HREADY is low
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_owner_r  <= OWNER_CPU;
      data_owner_r  <= OWNER_CPU;
      cpu_grant_r   <= 1'b1;
      dma_grant_r   <= 1'b0;
      beats_left_r  <= 5'd0;
      incr_active_r <= 1'b0;
    end else if (HREADY) begin
      addr_owner_r  <= addr_owner_nxt_s;
      data_owner_r  <= addr_owner_r;
      cpu_grant_r   <= (addr_owner_nxt_s == OWNER_CPU);
      dma_grant_r   <= (addr_owner_nxt_s == OWNER_DMA);
      beats_left_r  <= beats_left_nxt_s;
      incr_active_r <= incr_active_nxt_s;
    end
  end

  assign cpu_grant = cpu_grant_r;
  assign dma_grant = dma_grant_r;

endmodule
